bkm_iteration_ctrl: RTL and testbench

Sequencer for the BKM complex-arithmetic iteration loop in the FPU. It accepts one operation at a time through a valid/ready handshake and pulses `load` to initialise the datapath registers. It then steps the iteration counter from 1 to N_ITER, driving the CSD complex multiplier's digit inputs `d_x`/`d_y` and the per-iteration shift amount. When the loop finishes it holds the result until the downstream consumer accepts it.

---
 rtl/bkm_iteration_ctrl.sv | 142 ++++++++++++++
 tb/tb_bkm_iteration_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_iteration_ctrl.sv
// bkm_iteration_ctrl
// Sequencer for the BKM complex-arithmetic iteration loop. It accepts one
// operation at a time, pulses load to initialise the datapath, steps the
// iteration index 1..N_ITER while feeding CSD digits to the complex
// multiplier, and then holds the result until the consumer takes it.
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   in_valid / in_ready  operation request handshake
//   abort                synchronous cancel, returns to IDLE on next edge
//   stall                freezes the iteration while in ITER
//   sel_dx / sel_dy      digits from selection logic (00=0, 01=+1, 11=-1)
//   d_x / d_y            sanitised digits to the multiplier
//   load                 one-cycle operand load pulse
//   en                   datapath iteration register enable
//   iter                 current iteration index (shift amount)
//   out_valid/out_ready  result handshake
//   err                  sticky illegal-digit flag for the current operation
module bkm_iteration_ctrl #(
    parameter int W      = 64,
    parameter int N_ITER = 64,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    input  logic             stall,
    input  logic [1:0]       sel_dx,
    input  logic [1:0]       sel_dy,
    output logic [1:0]       d_x,
    output logic [1:0]       d_y,
    output logic             load,
    output logic             en,
    output logic [CNT_W-1:0] iter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    // Reject configurations the counter cannot represent.
    if (W < 1 || N_ITER < 2 || (64'd1 << CNT_W) <= 64'(N_ITER)) begin : g_bad_cfg
        $error("bkm_iteration_ctrl: invalid W/N_ITER/CNT_W combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] iter_next;
    logic             err_next;
    logic             step;
    logic             dx_bad;
    logic             dy_bad;

    // 2'b10 is not a valid CSD digit; it is replaced by zero on its own lane.
    assign dx_bad = (sel_dx == 2'b10);
    assign dy_bad = (sel_dy == 2'b10);
    assign step   = (state == ITER) && !stall;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            iter  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            iter  <= iter_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        iter_next  = iter;
        err_next   = err;
        in_ready   = 1'b0;
        load       = 1'b0;
        en         = 1'b0;
        out_valid  = 1'b0;
        d_x        = 2'b00;
        d_y        = 2'b00;

        case (state)
            IDLE: begin
                // A pending abort blocks the handshake even in IDLE.
                in_ready = !abort;
                if (in_valid && !abort) begin
                    state_next = LOAD;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                load       = 1'b1;
                iter_next  = CNT_W'(1);
                state_next = ITER;
            end
            ITER: begin
                en = step;
                if (step) begin
                    d_x = dx_bad ? 2'b00 : sel_dx;
                    d_y = dy_bad ? 2'b00 : sel_dy;
                    if (dx_bad || dy_bad) begin
                        err_next = 1'b1;
                    end
                    // The last index stays visible while the result waits.
                    if (iter == LAST_ITER) begin
                        state_next = DONE;
                    end else begin
                        iter_next = iter + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                    iter_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                iter_next  = '0;
            end
        endcase

        // Abort wins over every other input; err is deliberately kept.
        if (abort) begin
            state_next = IDLE;
            iter_next  = '0;
        end
    end

endmodule

// File: tb/tb_bkm_iteration_ctrl.sv
module tb_bkm_iteration_ctrl;

    localparam int W      = 64;
    localparam int N_ITER = 8;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             arst;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             stall;
    logic [1:0]       sel_dx;
    logic [1:0]       sel_dy;
    logic [1:0]       d_x;
    logic [1:0]       d_y;
    logic             load;
    logic             en;
    logic [CNT_W-1:0] iter;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    int checks;
    int failures;

    bkm_iteration_ctrl #(
        .W(W),
        .N_ITER(N_ITER),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .arst(arst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .abort(abort),
        .stall(stall),
        .sel_dx(sel_dx),
        .sel_dy(sel_dy),
        .d_x(d_x),
        .d_y(d_y),
        .load(load),
        .en(en),
        .iter(iter),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the active edge; outputs are checked at negedge.
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_slot();
        @(negedge clk);
    endtask

    // IDLE cycle offering a request, then the LOAD cycle.
    task automatic start_op(input string name);
        drive_slot();
        in_valid = 1'b1;
        sample_slot();
        check_val({name, "_idle_ready"}, in_ready, 1);
        check_val({name, "_idle_load"}, load, 0);
        drive_slot();
        in_valid = 1'b0;
        sample_slot();
        check_val({name, "_load"}, load, 1);
        check_val({name, "_load_en"}, en, 0);
        check_val({name, "_load_ready"}, in_ready, 0);
        check_val({name, "_load_err"}, err, 0);
        $display("op %s: accepted, load pulse seen", name);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        arst      = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        stall     = 1'b0;
        sel_dx    = 2'b00;
        sel_dy    = 2'b00;
        out_ready = 1'b0;

        // ---------------- reset state
        sample_slot();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_iter", iter, 0);
        check_val("rst_load", load, 0);
        check_val("rst_en", en, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_dx", d_x, 0);
        check_val("rst_err", err, 0);
        $display("reset: state checked");
        drive_slot();
        arst = 1'b0;

        // ---------------- nominal run with backpressure
        sel_dx = 2'b01;
        sel_dy = 2'b11;
        start_op("nom");
        for (int k = 1; k <= N_ITER; k++) begin
            drive_slot();
            sample_slot();
            check_val("nom_en", en, 1);
            check_val("nom_iter", iter, k);
            check_val("nom_dx", d_x, 2'b01);
            check_val("nom_dy", d_y, 2'b11);
            check_val("nom_load", load, 0);
            check_val("nom_out_valid", out_valid, 0);
        end
        for (int k = 0; k < 10; k++) begin
            drive_slot();
            in_valid = 1'b1;
            sample_slot();
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_en", en, 0);
            check_val("bp_dx", d_x, 0);
            check_val("bp_load", load, 0);
            check_val("bp_iter", iter, N_ITER);
        end
        drive_slot();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sample_slot();
        check_val("done_out_valid", out_valid, 1);
        drive_slot();
        out_ready = 1'b0;
        sample_slot();
        check_val("post_idle_ready", in_ready, 1);
        check_val("post_idle_out_valid", out_valid, 0);
        check_val("post_idle_iter", iter, 0);
        $display("op nom: completed after %0d iterations and 10 backpressure cycles", N_ITER);

        // ---------------- 3-cycle stall at iter=4
        start_op("stall");
        for (int c = 0; c < N_ITER + 3; c++) begin
            int exp_iter;
            logic exp_en;
            exp_iter = (c < 3) ? c + 1 : ((c < 7) ? 4 : c - 2);
            exp_en   = !(c >= 3 && c < 6);
            drive_slot();
            stall = !exp_en;
            sample_slot();
            check_val("stall_en", en, exp_en);
            check_val("stall_iter", iter, exp_iter);
            check_val("stall_dx", d_x, exp_en ? 2'b01 : 2'b00);
            check_val("stall_dy", d_y, exp_en ? 2'b11 : 2'b00);
            check_val("stall_out_valid", out_valid, 0);
        end
        drive_slot();
        stall     = 1'b0;
        out_ready = 1'b1;
        sample_slot();
        check_val("stall_done", out_valid, 1);
        drive_slot();
        out_ready = 1'b0;
        sample_slot();
        check_val("stall_back_idle", in_ready, 1);
        $display("op stall: result arrived 3 cycles late");

        // ---------------- illegal digits
        start_op("ill");
        for (int c = 0; c < N_ITER; c++) begin
            drive_slot();
            sel_dx = (c == 1) ? 2'b10 : 2'b01;
            sel_dy = (c == 4) ? 2'b10 : 2'b11;
            sample_slot();
            check_val("ill_iter", iter, c + 1);
            check_val("ill_dx", d_x, (c == 1) ? 2'b00 : 2'b01);
            check_val("ill_dy", d_y, (c == 4) ? 2'b00 : 2'b11);
            check_val("ill_err", err, (c >= 2) ? 1 : 0);
        end
        drive_slot();
        sel_dx    = 2'b01;
        sel_dy    = 2'b11;
        out_ready = 1'b1;
        sample_slot();
        check_val("ill_done", out_valid, 1);
        check_val("ill_done_err", err, 1);
        drive_slot();
        out_ready = 1'b0;
        sample_slot();
        check_val("ill_idle_err", err, 1);
        $display("op ill: err set and held");

        // ---------------- abort at iter=5 (err cleared by acceptance, then re-set)
        start_op("abt");
        for (int c = 0; c < 5; c++) begin
            drive_slot();
            sel_dx = (c == 0) ? 2'b10 : 2'b01;
            abort  = (c == 4);
            in_valid = (c == 4);
            sample_slot();
            check_val("abt_iter", iter, c + 1);
            check_val("abt_ready", in_ready, 0);
        end
        drive_slot();
        abort = 1'b0;
        sample_slot();
        check_val("abt_idle_ready", in_ready, 1);
        check_val("abt_idle_iter", iter, 0);
        check_val("abt_idle_out_valid", out_valid, 0);
        check_val("abt_idle_en", en, 0);
        check_val("abt_err_kept", err, 1);
        $display("op abt: aborted at iter=5");
        // in_valid still high: accepted on this edge
        drive_slot();
        in_valid = 1'b0;
        sample_slot();
        check_val("re_load", load, 1);
        check_val("re_err_clear", err, 0);
        for (int k = 1; k <= N_ITER; k++) begin
            drive_slot();
            sample_slot();
            check_val("re_iter", iter, k);
            check_val("re_en", en, 1);
        end
        drive_slot();
        out_ready = 1'b1;
        sample_slot();
        check_val("re_done", out_valid, 1);
        drive_slot();
        out_ready = 1'b0;
        $display("op re: full run after abort");

        // ---------------- abort held in IDLE blocks the handshake
        in_valid = 1'b1;
        abort    = 1'b1;
        sample_slot();
        check_val("abt_idle_block", in_ready, 0);
        drive_slot();
        in_valid = 1'b0;
        abort    = 1'b0;
        sample_slot();
        check_val("abt_idle_noload", load, 0);
        check_val("abt_idle_ready2", in_ready, 1);
        $display("abort in idle: request blocked");

        // ---------------- asynchronous reset mid-ITER
        start_op("rst");
        for (int c = 0; c < 3; c++) begin
            drive_slot();
            sample_slot();
        end
        check_val("rst_pre_iter", iter, 3);
        #2;
        arst = 1'b1;
        #1;
        check_val("arst_in_ready", in_ready, 1);
        check_val("arst_iter", iter, 0);
        check_val("arst_dx", d_x, 0);
        check_val("arst_dy", d_y, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_en", en, 0);
        drive_slot();
        arst = 1'b0;
        sample_slot();
        check_val("arst_after_iter", iter, 0);
        $display("op rst: async reset mid-iteration");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
